// File: rtl/mac_pe_pkg.sv
// rtl/mac_pe_pkg.sv - shared types and width helpers for the pipelined MAC PE
// Optional feature macro: MAC_PE_ACC_SAT_ROUND_EN (selects output width).
package mac_pe_pkg;

    function automatic int calc_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int calc_prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int calc_acc_w(input int w, input int guard_bits);
        return 2 * w + guard_bits;
    endfunction

    function automatic int calc_out_w(input int w, input int guard_bits);
`ifdef MAC_PE_ACC_SAT_ROUND_EN
        return w + 0 * guard_bits;
`else
        return calc_acc_w(w, guard_bits);
`endif
    endfunction

    localparam int PE_INT_BITS   = 7;
    localparam int PE_FRAC_BITS  = 9;
    localparam int PE_GUARD_BITS = 4;
    localparam int PE_W          = calc_w(PE_INT_BITS, PE_FRAC_BITS);
    localparam int PE_PROD_W     = calc_prod_w(PE_W);
    localparam int PE_ACC_W      = calc_acc_w(PE_W, PE_GUARD_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Field widths follow the package defaults; the top's parameters default to the same values.
    typedef struct packed {
        logic signed [PE_PROD_W-1:0] prod;
        logic signed [PE_ACC_W-1:0]  bias;
        logic                        first;
        logic                        last;
    } s1_payload_t;

endpackage

// File: rtl/mac_pe_sat_round.sv
// rtl/mac_pe_sat_round.sv - round-half-up and saturate an accumulator to a W-bit Qint.frac value
module mac_pe_sat_round #(
    parameter int ACC_W = 36,
    parameter int W     = 16,
    parameter int FRAC  = 9
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [W-1:0]     val_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W:0] HALF = {{(ACC_W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-W){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-W){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;

    // One extra MSB so the half-LSB addition cannot wrap the largest positive sum.
    assign rnd = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
    assign shr = rnd >>> FRAC;

    always_comb begin
        sat_o = 1'b0;
        val_o = shr[W-1:0];
        if (shr > MAXV) begin
            sat_o = 1'b1;
            val_o = {1'b0, {(W-1){1'b1}}};
        end else if (shr < MINV) begin
            sat_o = 1'b1;
            val_o = {1'b1, {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/mac_pe_acc.sv
// rtl/mac_pe_acc.sv - two-stage pipelined grouped fixed-point MAC with bias and backpressure
// Optional feature macro: MAC_PE_ACC_SAT_ROUND_EN (round/saturate result to W bits).
module mac_pe_acc
    import mac_pe_pkg::*;
#(
    parameter int para_int_bits   = PE_INT_BITS,
    parameter int para_frac_bits  = PE_FRAC_BITS,
    parameter int para_guard_bits = PE_GUARD_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_first,
    input  logic in_last,
    input  logic signed [calc_w(para_int_bits, para_frac_bits)-1:0] data_in_1,
    input  logic signed [calc_w(para_int_bits, para_frac_bits)-1:0] data_in_2,
    input  logic signed [calc_w(para_int_bits, para_frac_bits)-1:0] data_adder,
    output logic out_valid,
    input  logic out_ready,
    output logic [calc_out_w(calc_w(para_int_bits, para_frac_bits), para_guard_bits)-1:0] mac_out,
    output logic out_sat
);

    localparam int W     = calc_w(para_int_bits, para_frac_bits);
    localparam int PW    = calc_prod_w(W);
    localparam int ACC_W = calc_acc_w(W, para_guard_bits);

    logic signed [PW-1:0]    prod_c;
    logic signed [ACC_W-1:0] bias_c;
    logic signed [ACC_W-1:0] base_c;
    logic signed [ACC_W-1:0] sum_c;
    s1_payload_t             s1_d;
    s1_payload_t             s1_q;
    logic                    s1_valid_q;
    state_t                  state_q;
    state_t                  state_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] res_q;
    logic signed [ACC_W-1:0] res_d;
    logic                    stall;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = (state_q == DONE);

    assign prod_c = PW'(data_in_1) * PW'(data_in_2);
    assign bias_c = ACC_W'(data_adder) <<< para_frac_bits;

    always_comb begin
        s1_d       = '0;
        s1_d.prod  = prod_c;
        s1_d.bias  = bias_c;
        s1_d.first = in_first;
        s1_d.last  = in_last;
    end

    // A beat without first outside ACC starts a fresh group on a zero bias.
    assign base_c = s1_q.first ? $signed(s1_q.bias) :
                    (state_q == ACC) ? acc_q : '0;
    assign sum_c  = base_c + ACC_W'($signed(s1_q.prod));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (s1_valid_q) begin
            if (s1_q.last) begin
                res_d   = sum_c;
                state_d = DONE;
            end else begin
                acc_d   = sum_c;
                state_d = ACC;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // Every register is frozen while the result waits on the collector.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            state_q    <= IDLE;
            acc_q      <= '0;
            res_q      <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

`ifdef MAC_PE_ACC_SAT_ROUND_EN
    mac_pe_sat_round #(
        .ACC_W (ACC_W),
        .W     (W),
        .FRAC  (para_frac_bits)
    ) u_sat_round (
        .acc_i (res_q),
        .val_o (mac_out),
        .sat_o (out_sat)
    );
`else
    assign mac_out = res_q;
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_mac_pe_acc.sv
// tb/tb_mac_pe_acc.sv - directed self-checking bench for mac_pe_acc (raw or MAC_PE_ACC_SAT_ROUND_EN build)
module tb_mac_pe_acc;
    import mac_pe_pkg::*;

    localparam int W     = calc_w(PE_INT_BITS, PE_FRAC_BITS);
    localparam int OUT_W = calc_out_w(W, PE_GUARD_BITS);
`ifdef MAC_PE_ACC_SAT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_first = 1'b0;
    logic in_last = 1'b0;
    logic signed [W-1:0] data_in_1 = '0;
    logic signed [W-1:0] data_in_2 = '0;
    logic signed [W-1:0] data_adder = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [OUT_W-1:0] mac_out;
    logic out_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_pe_acc dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_last    (in_last),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .data_adder (data_adder),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mac_out    (mac_out),
        .out_sat    (out_sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pick(input logic [39:0] raw, input logic [39:0] rnd);
        return RND ? rnd : raw;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] bias,
                        input logic f, input logic l);
        chk("in_ready_on_send", 40'(in_ready), 40'd1);
        in_valid   = 1'b1;
        data_in_1  = a;
        data_in_2  = b;
        data_adder = bias;
        in_first   = f;
        in_last    = l;
        step();
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [39:0] raw, input logic [39:0] rnd,
                              input logic sat);
        chk({tag, "_valid"}, 40'(out_valid), 40'd1);
        chk({tag, "_data"}, 40'(mac_out), pick(raw, rnd));
        chk({tag, "_sat"}, 40'(out_sat), 40'(RND & sat));
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", 40'(out_valid), 40'd0);
        chk("rst_mac_out", 40'(mac_out), 40'd0);
        chk("rst_out_sat", 40'(out_sat), 40'd0);
        chk("rst_in_ready", 40'(in_ready), 40'd1);

        // single-beat group 1.5 * 2.0 + 0.5, result at t+2
        send(16'h0300, 16'h0400, 16'h0100, 1'b1, 1'b1);
        chk("single_lat_t1", 40'(out_valid), 40'd0);
        step();
        chk_result("single", 40'h00000E0000, 40'h0700, 1'b0);
        step();
        chk("single_drop", 40'(out_valid), 40'd0);

        // four back-to-back beats of 1.0 * 1.0
        send(16'h0200, 16'h0200, 16'h0000, 1'b1, 1'b0);
        send(16'h0200, 16'h0200, 16'h7FFF, 1'b0, 1'b0);
        send(16'h0200, 16'h0200, 16'h0000, 1'b0, 1'b0);
        chk("four_mid_no_out", 40'(out_valid), 40'd0);
        send(16'h0200, 16'h0200, 16'h0000, 1'b0, 1'b1);
        chk("four_lat_t1", 40'(out_valid), 40'd0);
        step();
        chk_result("four", 40'h0000100000, 40'h0800, 1'b0);
        step();
        chk("four_one_result", 40'(out_valid), 40'd0);

        // backpressure with a second group queued behind the first
        out_ready = 1'b0;
        send(16'h0200, 16'h0200, 16'h0200, 1'b1, 1'b1);
        send(16'h0400, 16'h0200, 16'h0100, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 40'(in_ready), 40'd0);
            chk_result("bp_hold", 40'h0000080000, 40'h0400, 1'b0);
            step();
        end
        chk_result("bp_last_hold", 40'h0000080000, 40'h0400, 1'b0);
        out_ready = 1'b1;
        step();
        chk_result("bp_second", 40'h00000A0000, 40'h0500, 1'b0);
        step();
        chk("bp_drain", 40'(out_valid), 40'd0);

        // positive saturation
        for (int i = 0; i < 4; i++) begin
            send(16'h7FFF, 16'h7FFF, 16'h0000, i == 0, i == 3);
        end
        step();
        chk_result("sat_pos", 40'h00FFFC0004, 40'h7FFF, 1'b1);
        step();

        // negative saturation
        for (int i = 0; i < 4; i++) begin
            send(16'h8000, 16'h7FFF, 16'h0000, i == 0, i == 3);
        end
        step();
        chk_result("sat_neg", 40'h0F00020000, 40'h8000, 1'b1);
        step();

        // restart inside a group: only 1.0 bias + 1.0 + 1.0 survive
        send(16'h0200, 16'h0200, 16'h0400, 1'b1, 1'b0);
        send(16'h0200, 16'h0200, 16'h0200, 1'b1, 1'b0);
        send(16'h0200, 16'h0200, 16'h0000, 1'b0, 1'b1);
        step();
        chk_result("restart", 40'h00000C0000, 40'h0600, 1'b0);
        step();

        // reset with a closing beat in flight drops the group
        send(16'h0200, 16'h0200, 16'h0100, 1'b1, 1'b0);
        send(16'h0200, 16'h0200, 16'h0000, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_no_out", 40'(out_valid), 40'd0);
            step();
        end
        send(16'h0100, 16'h0200, 16'h0000, 1'b1, 1'b1);
        step();
        chk_result("post_rst", 40'h0000020000, 40'h0100, 1'b0);
        step();

        // beat without first in IDLE uses a zero bias
        send(16'h0200, 16'h0200, 16'h7FFF, 1'b0, 1'b1);
        step();
        chk_result("no_first", 40'h0000040000, 40'h0200, 1'b0);
        step();

        // half-LSB rounding, positive then negative
        send(16'h0001, 16'h0100, 16'h0000, 1'b1, 1'b1);
        step();
        chk_result("half_pos", 40'h0000000100, 40'h0001, 1'b0);
        step();
        send(16'hFFFF, 16'h0100, 16'h0000, 1'b1, 1'b1);
        step();
        chk_result("half_neg", 40'h0FFFFFFF00, 40'h0000, 1'b0);
        step();
        chk("final_idle", 40'(out_valid), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_pe_acc.md
Name: mac_pe_acc

Overview:
- Pipelined, parametrised successor to the combinational fixed-point MAC PE.
- Accepts a stream of signed Qint.frac operand pairs under valid/ready.
- Accumulates the products of one group (first..last) on top of a per-group bias, then emits one result per group.
- Sits between the operand feeders and the result collector in the PE array. Provides backpressure and a registered, timing-clean datapath.

Parameters:
- para_int_bits, 7: integer bits of operands and bias (sign included).
- para_frac_bits, 9: fractional bits of operands and bias.
- para_guard_bits, 4: extra accumulator MSBs; supports 2^para_guard_bits full-scale products per group without wrap.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_first  in  1  beat opens a group; data_adder is sampled on this beat
- in_last  in  1  beat closes a group
- data_in_1  in  W  signed operand A, W = para_int_bits+para_frac_bits
- data_in_2  in  W  signed operand B
- data_adder  in  W  signed bias, Qint.frac, valid only with in_first
- out_valid  out  1  group result valid
- out_ready  in  1  collector accepts result
- mac_out  out  OUT_W  group result (see Optional Feature)
- out_sat  out  1  result was clamped (0 when macro absent)

Behaviour:
- Single clock; reset is synchronous and active-high.
- All arithmetic is signed two's complement.
- Product is 2W bits, Q(2I).(2F).
- ACC_W = 2W + para_guard_bits.
- Bias alignment: sign-extend data_adder to ACC_W, then shift left by para_frac_bits.
- Handshake:
  - A beat transfers when in_valid & in_ready.
  - A result transfers when out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall | rst_done_clear (i.e. in_ready = ~stall after reset).
  - During stall, every pipeline register holds its value.
- Pipeline:
  - Stage 1 registers the product, in_first, in_last, the aligned bias and s1_valid.
  - Stage 2 updates the accumulator.
  - Latency: a beat accepted at cycle t with in_last raises out_valid at t+2.
  - Throughput is one beat per cycle when not stalled.
- FSM (stage 2), states IDLE, ACC, DONE:
  - IDLE, s1 beat with first, no last: acc = bias + prod, go to ACC.
  - IDLE, s1 beat with first & last: result = bias + prod, go to DONE.
  - IDLE, s1 beat without first: treated as first with bias 0.
  - ACC, s1 beat with no flags: acc += prod.
  - ACC, s1 beat with last: result = acc + prod, go to DONE.
  - ACC, s1 beat with first: discard the partial sum and restart with the new bias (not an error).
  - DONE: out_valid = 1 and mac_out holds steady. On out_ready, go to IDLE, or to ACC/DONE if an s1 beat is consumed in the same cycle.
- Accumulator wraps modulo 2^ACC_W; no overflow flag when the macro is absent.
- Reset values: out_valid=0, mac_out=0, out_sat=0, in_ready=1 in the cycle after rst deasserts, FSM=IDLE, s1_valid=0, acc=0.
- Reset mid-group drops the partial sum and any held result; no output is produced for that group.
- Data inputs are ignored when in_valid=0. data_adder is ignored on beats without first.

Optional Feature:
- Macro: MAC_PE_ACC_SAT_ROUND_EN.
- Defined:
  - OUT_W = W.
  - Result is rounded half-up: add 1<<(para_frac_bits-1), then arithmetic shift right by para_frac_bits.
  - The value is then saturated to [-(2^(W-1)), 2^(W-1)-1].
  - out_sat = 1 when clamping occurred.
  - Rounding/saturation is combinational on the DONE result register.
- Undefined: OUT_W = ACC_W, mac_out is the raw accumulator, out_sat tied to 0.

Decomposition:
- Package mac_pe_pkg holds:
  - the FSM state typedef (IDLE/ACC/DONE);
  - width functions for W, product width, ACC_W and OUT_W;
  - the stage-1 payload struct (prod, bias, first, last).
- One sub-module, mac_pe_sat_round: ACC_W input, W output plus sat flag, purely combinational, instantiated only under the macro.

Test Plan:
- Single-beat group: A=0x0300 (1.5), B=0x0400 (2.0), bias=0x0100 (0.5), first & last.
  - Raw build: mac_out=0xE0000 at t+2.
  - Macro build: mac_out=0x0700, out_sat=0.
- 4-beat group, all products 1.0 (0x0200 x 0x0200), bias 0, back-to-back valid: exactly one result, raw 0x100000, two cycles after the last beat.
- Backpressure: hold out_ready=0 for 5 cycles while DONE.
  - in_ready=0 throughout; mac_out stable; a queued second group is not lost or corrupted.
  - Second result follows the first on consecutive accepted cycles.
- Macro build, 4 beats of 0x7FFF x 0x7FFF: mac_out=0x7FFF, out_sat=1. Same with A=0x8000, B=0x7FFF: mac_out=0x8000, out_sat=1.
- Abort/restart:
  - first beat; second beat with first (bias 0x0200, prod 1.0); then last beat with prod 1.0. Result must be 3.0 only.
  - Separately, assert rst mid-group: out_valid stays 0 and the next group's result is correct.
- Rounding at half-LSB: a product of 2^-10 with bias 0 rounds to 0x0001 in the macro build; a product of -2^-10 rounds to 0x0000.
